// File: rtl/timer_display.sv
// Four-digit multiplexed 7-segment countdown display with colon blink and an end-of-time indication.
// Define TIMER_DISPLAY_ALARM_EN to build the blinking ALARM state and buzzer; without it RUN ends directly in DONE.
module timer_display #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_DIV    = 50000000,
    parameter int unsigned ALARM_BLINKS = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [16:1] bcd_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        buzzer,
    output logic        alarm
);
    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

`ifdef TIMER_DISPLAY_ALARM_EN
    localparam int unsigned HALF_W = (ALARM_BLINKS > 1) ? $clog2(ALARM_BLINKS) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(ALARM_BLINKS - 1);
    typedef enum logic [1:0] {IDLE, RUN, ALARM, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    logic               r_rstSync;
    logic               w_rstn;
    state_t             r_state;
    state_t             w_nextState;
    logic [16:1]        r_bcd;
    logic [SCAN_W-1:0]  r_scanCnt;
    logic [1:0]         r_digitIdx;
    logic [BLINK_W-1:0] r_blinkCnt;
    logic               r_blinkOn;
    logic               w_blinkTerm;
    logic               w_zero;
    logic               w_colonOn;
    logic               w_blank;
    logic [3:0]         w_nibble;
    logic [3:0]         w_anNext;
    logic [6:0]         w_segNext;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;
`ifdef TIMER_DISPLAY_ALARM_EN
    logic [HALF_W-1:0]  r_halfCnt;
`endif

    // Reset asserts asynchronously; its release is retimed so logic first acts on the second edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_rstSync <= 1'b0;
        else       r_rstSync <= 1'b1;
    end
    assign w_rstn = r_rstSync;

    always_ff @(posedge clk or negedge w_rstn) begin
        if (!w_rstn) begin
            r_bcd      <= '0;
            r_scanCnt  <= '0;
            r_digitIdx <= 2'd0;
        end else begin
            r_bcd <= bcd_in;
            if (r_scanCnt == SCAN_LAST) begin
                r_scanCnt  <= '0;
                r_digitIdx <= r_digitIdx + 2'd1;
            end else begin
                r_scanCnt <= r_scanCnt + SCAN_W'(1);
            end
        end
    end

    assign w_zero      = (r_bcd == 16'h0000);
    assign w_blinkTerm = (r_blinkCnt == BLINK_LAST);

    always_ff @(posedge clk or negedge w_rstn) begin
        if (!w_rstn) r_state <= IDLE;
        else         r_state <= w_nextState;
    end

    // Dropping start wins over every other transition.
    always_comb begin
        w_nextState = r_state;
        if (!start) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:  w_nextState = w_zero ? DONE : RUN;
`ifdef TIMER_DISPLAY_ALARM_EN
                RUN:   if (w_zero) w_nextState = ALARM;
                ALARM: if (w_blinkTerm && (r_halfCnt == HALF_LAST)) w_nextState = DONE;
`else
                RUN:   if (w_zero) w_nextState = DONE;
`endif
                DONE:  w_nextState = DONE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Blink timing restarts from an "on" half-period whenever a state is entered.
    always_ff @(posedge clk or negedge w_rstn) begin
        if (!w_rstn) begin
            r_blinkCnt <= '0;
            r_blinkOn  <= 1'b1;
`ifdef TIMER_DISPLAY_ALARM_EN
            r_halfCnt  <= '0;
`endif
        end else if (w_nextState != r_state) begin
            r_blinkCnt <= '0;
            r_blinkOn  <= 1'b1;
`ifdef TIMER_DISPLAY_ALARM_EN
            r_halfCnt  <= '0;
`endif
        end else if (r_state != IDLE && r_state != DONE) begin
            if (w_blinkTerm) begin
                r_blinkCnt <= '0;
                r_blinkOn  <= ~r_blinkOn;
`ifdef TIMER_DISPLAY_ALARM_EN
                r_halfCnt  <= r_halfCnt + HALF_W'(1);
`endif
            end else begin
                r_blinkCnt <= r_blinkCnt + BLINK_W'(1);
            end
        end
    end

    assign w_colonOn = (r_state == RUN) ? r_blinkOn : 1'b1;
`ifdef TIMER_DISPLAY_ALARM_EN
    assign w_blank = (r_state == ALARM) && !r_blinkOn;
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_nibble = r_bcd[16:13];
        w_anNext = 4'b0111;
        case (r_digitIdx)
            2'd0: begin w_nibble = r_bcd[16:13]; w_anNext = 4'b0111; end
            2'd1: begin w_nibble = r_bcd[12:9];  w_anNext = 4'b1011; end
            2'd2: begin w_nibble = r_bcd[8:5];   w_anNext = 4'b1101; end
            default: begin w_nibble = r_bcd[4:1]; w_anNext = 4'b1110; end
        endcase
        if (w_blank) w_anNext = 4'b1111;

        w_segNext = 7'b1111111;
        case (w_nibble)
            4'd0: w_segNext = 7'b1000000;
            4'd1: w_segNext = 7'b1111001;
            4'd2: w_segNext = 7'b0100100;
            4'd3: w_segNext = 7'b0110000;
            4'd4: w_segNext = 7'b0011001;
            4'd5: w_segNext = 7'b0010010;
            4'd6: w_segNext = 7'b0000010;
            4'd7: w_segNext = 7'b1111000;
            4'd8: w_segNext = 7'b0000000;
            4'd9: w_segNext = 7'b0010000;
            default: w_segNext = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or negedge w_rstn) begin
        if (!w_rstn) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_anNext;
            r_seg <= w_segNext;
            r_dp  <= !((r_digitIdx == 2'd1) && w_colonOn);
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

`ifdef TIMER_DISPLAY_ALARM_EN
    assign buzzer = (r_state == ALARM);
    assign alarm  = (r_state == ALARM) || (r_state == DONE);
`else
    assign buzzer = 1'b0;
    assign alarm  = (r_state == DONE);
`endif
endmodule

// File: tb/tb_timer_display.sv
// Self-checking bench for timer_display: digit table, randomized scan against a delay-line model,
// and hand sequences for RUN colon blink, expiry, start drop and asynchronous reset.
`timescale 1ns/1ps
module tb_timer_display;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_DIV    = 8;
    localparam int ALARM_BLINKS = 4;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [16:1] bcd_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        buzzer;
    logic        alarm;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cyc0  = 0;
    logic [16:1] bcdD1 = '0;
    logic [16:1] bcdD2 = '0;

    typedef struct {
        logic [16:1] bcd;
        int          idx;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;
    vec_t vecs[12];

    timer_display #(
        .SCAN_DIV(SCAN_DIV),
        .BLINK_DIV(BLINK_DIV),
        .ALARM_BLINKS(ALARM_BLINKS)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .bcd_in(bcd_in),
        .an(an),
        .seg(seg),
        .dp(dp),
        .buzzer(buzzer),
        .alarm(alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge count and a two-deep history of bcd_in: the display shows the value from two edges back.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        bcdD1 <= bcd_in;
        bcdD2 <= bcdD1;
    end

    function automatic logic [6:0] segOf(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int expIdx();
        return ((cyc - cyc0) / SCAN_DIV + 1) % 4;
    endfunction

    function automatic logic [3:0] nibOf(input logic [16:1] v, input int i);
        return 4'(v >> (4 * (3 - i)));
    endfunction

    function automatic logic [3:0] anOf(input int i);
        return ~(4'b1000 >> i);
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [16:1] b, input logic s);
        bcd_in = b;
        start  = s;
    endtask

    task automatic checkOutput(input string tag, input bit blank, input bit doDp, input bit colon);
        int i;
        i = expIdx();
        if (blank) begin
            compare({tag, ".an"}, 32'(an), 32'(4'b1111));
        end else begin
            compare({tag, ".an"}, 32'(an), 32'(anOf(i)));
            compare({tag, ".seg"}, 32'(seg), 32'(segOf(nibOf(bcdD2, i))));
            if (doDp) compare({tag, ".dp"}, 32'(dp), 32'(!(i == 1 && colon)));
        end
    endtask

    // After reset release: first lit digit must be index 0, then lock the scan model onto the 0->1 step.
    task automatic resync(input string tag);
        logic [3:0] prev;
        bit found;
        for (int n = 0; n < 10 && an == 4'b1111; n++) @(negedge clk);
        compare({tag, ".firstDigit"}, 32'(an), 32'(4'b0111));
        prev  = an;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (prev == 4'b0111 && an == 4'b1011) begin
                found = 1'b1;
                cyc0  = cyc;
            end
            prev = an;
        end
        compare({tag, ".scanAlign"}, 32'(found), 32'd1);
    endtask

    task automatic runCheck(input int offset, input int cycles);
        bit colon;
        applyStimulus(16'h0001, 1'b0);
        repeat (4) @(negedge clk);
        for (int n = 0; n < 16 && ((cyc - cyc0) % 16) != offset; n++) @(negedge clk);
        start = 1'b1;
        for (int m = 0; m < cycles; m++) begin
            @(negedge clk);
            colon = (m == 0) || ((((m - 1) / BLINK_DIV) % 2) == 0);
            checkOutput("run", 1'b0, 1'b1, colon);
            compare("run.alarm", 32'(alarm), 32'd0);
            compare("run.buzzer", 32'(buzzer), 32'd0);
        end
    endtask

    task automatic enterExpiry();
        applyStimulus(16'h0001, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        bcd_in = 16'h0000;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d", total);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{16'h1203, 0, 4'b0111, 7'b1111001, 1'b1};
        vecs[1]  = '{16'h1203, 1, 4'b1011, 7'b0100100, 1'b0};
        vecs[2]  = '{16'h1203, 2, 4'b1101, 7'b1000000, 1'b1};
        vecs[3]  = '{16'h1203, 3, 4'b1110, 7'b0110000, 1'b1};
        vecs[4]  = '{16'h45A9, 2, 4'b1101, 7'b1111111, 1'b1};
        vecs[5]  = '{16'h45A9, 0, 4'b0111, 7'b0011001, 1'b1};
        vecs[6]  = '{16'h45A9, 1, 4'b1011, 7'b0010010, 1'b0};
        vecs[7]  = '{16'h45A9, 3, 4'b1110, 7'b0010000, 1'b1};
        vecs[8]  = '{16'h678F, 0, 4'b0111, 7'b0000010, 1'b1};
        vecs[9]  = '{16'h678F, 1, 4'b1011, 7'b1111000, 1'b0};
        vecs[10] = '{16'h678F, 2, 4'b1101, 7'b0000000, 1'b1};
        vecs[11] = '{16'h678F, 3, 4'b1110, 7'b1111111, 1'b1};

        rstn = 1'b0;
        applyStimulus(16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        compare("reset.an", 32'(an), 32'(4'b1111));
        compare("reset.seg", 32'(seg), 32'(7'b1111111));
        compare("reset.dp", 32'(dp), 32'd1);
        compare("reset.buzzer", 32'(buzzer), 32'd0);
        compare("reset.alarm", 32'(alarm), 32'd0);

        bcd_in = 16'h1203;
        rstn   = 1'b1;
        resync("boot");

        // Digit table in IDLE: colon on, so dp is low only on the min-ones digit.
        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].bcd, 1'b0);
            repeat (3) @(negedge clk);
            for (int n = 0; n < 16 && expIdx() != vecs[v].idx; n++) @(negedge clk);
            compare($sformatf("vec%0d.an", v), 32'(an), 32'(vecs[v].an));
            compare($sformatf("vec%0d.seg", v), 32'(seg), 32'(vecs[v].seg));
            compare($sformatf("vec%0d.dp", v), 32'(dp), 32'(vecs[v].dp));
        end

        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            checkOutput("rand", 1'b0, 1'b1, 1'b1);
            compare("rand.alarm", 32'(alarm), 32'd0);
            if ($urandom_range(0, 3) == 0) bcd_in = 16'($urandom);
        end

        // Two RUN entries at scan offsets that put the min-ones digit in opposite colon phases.
        runCheck(6, 24);
        start = 1'b0;
        @(negedge clk);
        compare("idle.alarm", 32'(alarm), 32'd0);
        runCheck(14, 24);

        bcd_in = 16'h0000;
        repeat (2) @(negedge clk);
        compare("expire.alarm", 32'(alarm), 32'd1);
`ifdef TIMER_DISPLAY_ALARM_EN
        compare("expire.buzzer", 32'(buzzer), 32'd1);
        for (int m = 1; m <= 48; m++) begin
            @(negedge clk);
            checkOutput("alarm", (m >= 9 && m <= 16) || (m >= 25 && m <= 32), m >= 34, 1'b1);
            compare("alarm.buzzer", 32'(buzzer), 32'(m < 32));
            compare("alarm.flag", 32'(alarm), 32'd1);
        end
`else
        compare("expire.buzzer", 32'(buzzer), 32'd0);
        for (int m = 1; m <= 40; m++) begin
            @(negedge clk);
            checkOutput("done", 1'b0, 1'b1, 1'b1);
            compare("done.buzzer", 32'(buzzer), 32'd0);
            compare("done.alarm", 32'(alarm), 32'd1);
        end
`endif

        start = 1'b0;
        enterExpiry();
        repeat (5) @(negedge clk);
        compare("preDrop.alarm", 32'(alarm), 32'd1);
        start = 1'b0;
        @(negedge clk);
        compare("drop.alarm", 32'(alarm), 32'd0);
        compare("drop.buzzer", 32'(buzzer), 32'd0);

        start = 1'b1;
        @(negedge clk);
        compare("idleZero.alarm", 32'(alarm), 32'd1);
        compare("idleZero.buzzer", 32'(buzzer), 32'd0);

        start = 1'b0;
        enterExpiry();
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        compare("asyncRst.alarm", 32'(alarm), 32'd0);
        compare("asyncRst.buzzer", 32'(buzzer), 32'd0);
        compare("asyncRst.an", 32'(an), 32'(4'b1111));
        start = 1'b0;
        repeat (2) @(negedge clk);
        compare("inRst.seg", 32'(seg), 32'(7'b1111111));
        bcd_in = 16'h0935;
        rstn   = 1'b1;
        resync("reboot");
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            checkOutput("post", 1'b0, 1'b1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
